// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the single-port memory arbiter.
// Holds the FSM encoding, the owner encoding and the counter widths.
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t WAIT   = 2'd2;
    localparam state_t RESP   = 2'd3;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 4.
    localparam int unsigned LAT_W    = 3;
    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Data wins ties unless the fetch side has been starved for STARVE_MAX arbitrations.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                i_req_i,
    input  logic                d_req_i,
    input  logic                flush_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output logic                valid_o,
    output owner_t              owner_o
);

    logic i_elig;
    logic starved;

    assign i_elig  = i_req_i & ~flush_i;
    assign starved = (starve_cnt_i == STARVE_W'(STARVE_MAX));

    always_comb begin
        valid_o = i_elig | d_req_i;
        owner_o = OWN_D;
        if (i_elig && (!d_req_i || starved)) begin
            owner_o = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store using
// request/grant handshakes, registered responses and a fetch flush hook.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IGnt,
    output logic              IValid,
    output logic [DATA_W-1:0] IData,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic              DGnt,
    output logic              DValid,
    output logic [DATA_W-1:0] DRData,
    input  logic              Flush,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic              Busy
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                kill_q, kill_d;
    logic [DATA_W-1:0]   idata_q, idata_d;
    logic [DATA_W-1:0]   drdata_q, drdata_d;

    logic   pick_valid;
    owner_t pick_owner;
    logic   access;
    logic   fetch_busy;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_req_i      (IReq),
        .d_req_i      (DReq),
        .flush_i      (Flush),
        .starve_cnt_i (starve_q),
        .valid_o      (pick_valid),
        .owner_o      (pick_owner)
    );

    assign fetch_busy = (state_q != IDLE) && (owner_q == OWN_I);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        kill_d   = kill_q;
        idata_d  = idata_q;
        drdata_d = drdata_q;

        // A flush at any point of an outstanding fetch kills its response.
        if (fetch_busy && Flush) begin
            kill_d = 1'b1;
        end

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (pick_valid) begin
                    state_d = ACCESS;
                    owner_d = pick_owner;
                    kill_d  = 1'b0;
                    if (pick_owner == OWN_D) begin
                        addr_d  = DAddr;
                        we_d    = DWe;
                        wdata_d = DWData;
                    end else begin
                        addr_d  = IAddr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
                if (!IReq || (pick_valid && pick_owner == OWN_I)) begin
                    starve_d = '0;
                end else if (pick_valid && starve_q != STARVE_W'(STARVE_MAX)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            ACCESS: begin
                state_d = WAIT;
                lat_d   = LAT_W'(MEM_LAT - 1);
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                    if (owner_q == OWN_D && !we_q) begin
                        drdata_d = MemRData;
                    end
                    if (owner_q == OWN_I && !kill_q && !Flush) begin
                        idata_d = MemRData;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            lat_q    <= '0;
            starve_q <= '0;
            kill_q   <= 1'b0;
            idata_q  <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            kill_q   <= kill_d;
            idata_q  <= idata_d;
            drdata_q <= drdata_d;
        end
    end

    assign access   = (state_q == ACCESS);
    assign MemEn    = access;
    assign MemWe    = access & we_q;
    assign MemAddr  = access ? addr_q : '0;
    assign MemWData = access ? wdata_q : '0;
    assign IGnt     = access && (owner_q == OWN_I);
    assign DGnt     = access && (owner_q == OWN_D);
    assign IValid   = (state_q == RESP) && (owner_q == OWN_I) && !kill_q && !Flush;
    assign DValid   = (state_q == RESP) && (owner_q == OWN_D);
    assign IData    = idata_q;
    assign DRData   = drdata_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one instance at MEM_LAT=1 with a
// memory model, one at MEM_LAT=3 with a constant read word.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req, i_gnt, i_valid;
    logic [31:0] i_addr, i_data;
    logic        d_req, d_we, d_gnt, d_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        flush;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        d3_ireq, d3_ignt, d3_ivalid, d3_dreq, d3_dgnt, d3_dvalid;
    logic [31:0] d3_idata, d3_drdata, d3_maddr, d3_mwdata;
    logic        d3_men, d3_mwe, d3_busy;

    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe;
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    int tests;
    int fails;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .IReq(i_req), .IAddr(i_addr), .IGnt(i_gnt), .IValid(i_valid), .IData(i_data),
        .DReq(d_req), .DWe(d_we), .DAddr(d_addr), .DWData(d_wdata),
        .DGnt(d_gnt), .DValid(d_valid), .DRData(d_rdata),
        .Flush(flush),
        .MemEn(mem_en), .MemWe(mem_we), .MemAddr(mem_addr), .MemWData(mem_wdata),
        .MemRData(mem_rdata), .Busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .Clk(clk), .Rst_n(rst_n),
        .IReq(d3_ireq), .IAddr(32'h0), .IGnt(d3_ignt), .IValid(d3_ivalid), .IData(d3_idata),
        .DReq(d3_dreq), .DWe(1'b0), .DAddr(32'h40), .DWData(32'h0),
        .DGnt(d3_dgnt), .DValid(d3_dvalid), .DRData(d3_drdata),
        .Flush(1'b0),
        .MemEn(d3_men), .MemWe(d3_mwe), .MemAddr(d3_maddr), .MemWData(d3_mwdata),
        .MemRData(32'hC0FFEE03), .Busy(d3_busy)
    );

    always #5 clk = ~clk;

    // Single-cycle-latency memory; read word is 0 except the cycle after a read command.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        rd_pipe <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 32'h0;
    end
    assign mem_rdata = rd_pipe;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        step();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({busy, mem_en, mem_we, i_gnt, d_gnt, i_valid, d_valid} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 0", {busy, mem_en, mem_we, i_gnt, d_gnt, i_valid, d_valid});
        end
        tests++;
        if ({mem_addr, mem_wdata, i_data, d_rdata} !== 128'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, i_data, d_rdata});
        end
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 32'h10;
        step();
        tests++;
        if ({i_gnt, d_gnt, mem_en, mem_we, busy} !== 5'b10101 || mem_addr !== 32'h10) begin
            fails++;
            $display("FAIL fetch_cmd got gnt/en/we/busy=%b addr=%h want 10101 addr=10", {i_gnt, d_gnt, mem_en, mem_we, busy}, mem_addr);
        end
        i_req = 1'b0;
        step();
        tests++;
        if ({busy, i_valid, mem_en, mem_addr} !== {3'b100, 32'h0}) begin
            fails++;
            $display("FAIL fetch_wait got busy/valid/en=%b addr=%h want 100 addr=0", {busy, i_valid, mem_en}, mem_addr);
        end
        step();
        tests++;
        if (i_valid !== 1'b1 || busy !== 1'b1 || i_data !== 32'hA5A50001) begin
            fails++;
            $display("FAIL fetch_resp got valid=%b busy=%b data=%h want 1 1 a5a50001", i_valid, busy, i_data);
        end
        step();
        tests++;
        if (i_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL fetch_idle got valid=%b busy=%b want 0 0", i_valid, busy);
        end
    endtask

    task automatic test_write_read();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        step();
        tests++;
        if ({d_gnt, i_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_cmd got %b addr=%h wd=%h want 1011 20 deadbeef", {d_gnt, i_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
        step();
        step();
        tests++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h0) begin
            fails++;
            $display("FAIL write_ack got valid=%b rdata=%h want 1 0", d_valid, d_rdata);
        end
        step();
        d_req = 1'b1;
        step();
        tests++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL read_cmd got gnt=%b we=%b want 1 0", d_gnt, mem_we);
        end
        d_req = 1'b0;
        step();
        step();
        tests++;
        if (d_valid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL read_resp got valid=%b rdata=%h want 1 deadbeef", d_valid, d_rdata);
        end
        step();
    endtask

    task automatic test_starvation();
        logic exp_gnt, exp_i;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int c = 1; c <= 29; c++) begin
            step();
            exp_gnt = ((c - 1) % 3 == 0);
            exp_i   = exp_gnt && (((c - 1) / 3) % 5 == 4);
            tests++;
            if ({i_gnt, d_gnt} !== {exp_i, exp_gnt && !exp_i}) begin
                fails++;
                $display("FAIL starve_order cycle %0d got i/d=%b want %b", c, {i_gnt, d_gnt}, {exp_i, exp_gnt && !exp_i});
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL starve_drain got busy=%b want 0", busy);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; i_req = 1'b1; i_addr = 32'h30;
        step();
        tests++;
        if (i_gnt !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_arb got gnt=%b busy=%b want 0 0", i_gnt, busy);
        end
        flush = 1'b0;
        step();
        i_req = 1'b0;
        tests++;
        if (i_gnt !== 1'b1 || mem_addr !== 32'h30) begin
            fails++;
            $display("FAIL flush_gnt got gnt=%b addr=%h want 1 30", i_gnt, mem_addr);
        end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if (i_valid !== 1'b0 || busy !== 1'b1 || i_data !== 32'hA5A50001) begin
            fails++;
            $display("FAIL flush_resp got valid=%b busy=%b data=%h want 0 1 a5a50001", i_valid, busy, i_data);
        end
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle got busy=%b want 0", busy);
        end
        i_req = 1'b1;
        step();
        i_req = 1'b0;
        step();
        step();
        tests++;
        if (i_valid !== 1'b1 || i_data !== 32'h12345678) begin
            fails++;
            $display("FAIL flush_refetch got valid=%b data=%h want 1 12345678", i_valid, i_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        step();
        d_req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, mem_en, d_valid, d_gnt} !== 4'b0 || d_rdata !== 32'h0 || i_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid got ctrl=%b rdata=%h idata=%h want 0", {busy, mem_en, d_valid, d_gnt}, d_rdata, i_data);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            tests++;
            if (d_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_release cycle %0d got valid=%b busy=%b want 0 0", c, d_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back_lat3();
        logic exp_g, exp_v;
        d3_dreq = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            exp_g = (c == 1 || c == 6 || c == 11);
            exp_v = (c == 5 || c == 10);
            tests++;
            if ({d3_dgnt, d3_dvalid} !== {exp_g, exp_v}) begin
                fails++;
                $display("FAIL lat3_timing cycle %0d got gnt/valid=%b want %b", c, {d3_dgnt, d3_dvalid}, {exp_g, exp_v});
            end
            if (c == 5) begin
                tests++;
                if (d3_drdata !== 32'hC0FFEE03) begin
                    fails++;
                    $display("FAIL lat3_data got %h want c0ffee03", d3_drdata);
                end
            end
        end
        d3_dreq = 1'b0;
        for (int c = 0; c < 5; c++) step();
        tests++;
        if (d3_busy !== 1'b0) begin
            fails++;
            $display("FAIL lat3_idle got busy=%b want 0", d3_busy);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        flush = 1'b0; d3_ireq = 1'b0; d3_dreq = 1'b0;
        pl_en = 1'b0; pl_addr = 8'h0; pl_data = 32'h0;
        tests = 0; fails = 0;
        step();
        test_reset();
        rst_n = 1'b1;
        preload(8'h10, 32'hA5A50001);
        preload(8'h30, 32'h12345678);
        test_fetch();
        test_write_read();
        test_starvation();
        test_flush();
        test_reset_mid();
        test_back_to_back_lat3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single-port instruction/data memory and shares it between two requesters: the instruction-fetch side (PC path) and the load/store side (data path).
- Replaces the dual-port memory arrangement with a request/grant protocol.
- Provides registered responses, data-side priority with a fetch anti-starvation counter, and a flush hook driven by the control unit's Clear.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data word width.
- MEM_LAT, 1, memory read latency in cycles after the command cycle (legal 1..4).
- STARVE_MAX, 4, consecutive lost arbitrations after which a waiting fetch wins (legal 1..15).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- IReq  in  1  fetch request; held with IAddr until IGnt.
- IAddr  in  ADDR_W  fetch address.
- IGnt  out  1  one-cycle pulse: fetch command is on the memory port this cycle.
- IValid  out  1  one-cycle pulse: IData valid.
- IData  out  DATA_W  registered fetch data.
- DReq  in  1  data request; held with DWe/DAddr/DWData until DGnt.
- DWe  in  1  1 = write, 0 = read.
- DAddr  in  ADDR_W  data address.
- DWData  in  DATA_W  write data.
- DGnt  out  1  one-cycle pulse: data command is on the memory port this cycle.
- DValid  out  1  one-cycle pulse: read data valid, or write acknowledge.
- DRData  out  DATA_W  registered read data; holds its previous value on a write ack.
- Flush  in  1  discard the outstanding or arbitrating fetch (driven by Clear).
- MemEn  out  1  memory command strobe.
- MemWe  out  1  memory write enable, qualified by MemEn.
- MemAddr  out  ADDR_W  memory address.
- MemWData  out  DATA_W  memory write data.
- MemRData  in  DATA_W  memory read data, valid MEM_LAT cycles after the MemEn cycle.
- Busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; starve counter 0; owner cleared. Reset may assert in any state; any outstanding response is dropped and no Valid pulse follows reset release.
- States:
  - IDLE, RESP: arbitration states. If any eligible request is present, latch owner, address, write enable and write data, then go to ACCESS; otherwise go to IDLE.
  - ACCESS: exactly 1 cycle. MemEn=1, MemWe=DWe latched (0 for fetch). The owner's Gnt=1 in this cycle.
  - WAIT: MEM_LAT cycles, counted by a latency counter. MemRData is captured into IData/DRData at the end of the last WAIT cycle (reads only).
  - RESP: 1 cycle. The owner's Valid=1, then arbitration as above.
- Timing (request sampled in cycle 0): Gnt in cycle 1; Valid in cycle MEM_LAT+2. Back-to-back grants are spaced MEM_LAT+2 cycles apart.
- Arbitration:
  - DReq wins ties unless starve_cnt == STARVE_MAX, in which case IReq wins.
  - starve_cnt increments (saturating at STARVE_MAX) on every arbitration where IReq=1 and data wins.
  - starve_cnt clears on a fetch grant, or in any arbitration cycle with IReq=0.
- Flush:
  - Flush=1 in an arbitration cycle makes IReq ineligible that cycle.
  - Flush=1 in any cycle of an outstanding fetch (ACCESS/WAIT/RESP) suppresses that fetch's IValid. IData is not updated. Memory timing and state sequence are unchanged.
  - Data transactions are unaffected by Flush.
- MemAddr, MemWData and MemWe are 0 outside ACCESS.
- Requests are never dropped: an unserved request simply waits, provided the requester holds it.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ACCESS, WAIT, RESP), owner enum (OWN_I, OWN_D), latency-counter width constant.
- One sub-module, mem_arb_pick: combinational winner selection (inputs IReq, DReq, Flush, starve_cnt, STARVE_MAX).
- Counters and the FSM stay in mem_arbiter.

Test Plan:
- Fetch only (MEM_LAT=1), IReq with IAddr=0x10, mem[0x10]=0xA5A50001 -> IGnt and MemEn in cycle 1 with MemAddr=0x10, MemWe=0; IValid in cycle 3 with IData=0xA5A50001; Busy high cycles 1–3.
- Data write DAddr=0x20, DWData=0xDEADBEEF, DWe=1 -> MemWe=1 in cycle 1, DValid in cycle 3. A following read of 0x20 -> DRData=0xDEADBEEF.
- IReq and DReq held continuously (STARVE_MAX=4, MEM_LAT=1) -> grant order D,D,D,D,I,D,D,D,D,I, with grants every 3 cycles.
- Flush pulsed during the WAIT of a fetch to 0x30 -> no IValid, IData unchanged, IDLE reached on schedule. The next fetch of 0x30 returns normally.
- Rst_n low during WAIT of a data read -> all outputs 0 immediately. After release, no DValid and Busy=0 until a new request arrives.
- DReq held with MEM_LAT=3 -> DGnt in cycles 1, 6, 11; DValid in cycles 5, 10.
